// File: rtl/conv_pkg.sv
// Shared constants and types for the conv1 window generator slice.
package conv_pkg;

    localparam int KERNEL_SIZE = 3;
    localparam int WIN_N       = KERNEL_SIZE * KERNEL_SIZE;
    localparam int DATA_W      = 32;
    localparam int IMG_W       = 28;
    localparam int IMG_H       = 28;

    typedef logic [DATA_W-1:0] word_t;
    typedef word_t win_t [0:WIN_N-1];

    // Origin (top row / left column) of the last window along one axis for a given stride.
    function automatic int last_origin(input int n, input int stride);
        return ((n - KERNEL_SIZE) / stride) * stride;
    endfunction

endpackage

// File: rtl/conv_window_gen_if.sv
// Pixel-in / window-out handshake bundle for conv_window_gen.
interface conv_window_gen_if
    import conv_pkg::*;
#(
    parameter int DATA_W = conv_pkg::DATA_W,
    parameter int IMG_W  = conv_pkg::IMG_W,
    parameter int IMG_H  = conv_pkg::IMG_H
);

    logic                       pix_valid;
    logic                       pix_ready;
    logic [DATA_W-1:0]          pix_data;
    logic                       win_valid;
    logic                       win_ready;
    logic [DATA_W-1:0]          win_data [0:WIN_N-1];
    logic [$clog2(IMG_H)-1:0]   win_row;
    logic [$clog2(IMG_W)-1:0]   win_col;
    logic                       frame_done;

    modport master (
        output pix_valid, pix_data, win_ready,
        input  pix_ready, win_valid, win_data, win_row, win_col, frame_done
    );

    modport slave (
        input  pix_valid, pix_data, win_ready,
        output pix_ready, win_valid, win_data, win_row, win_col, frame_done
    );

endinterface

// File: rtl/conv_line_buf.sv
// One-row delay memory: combinational read and clocked write at the same column address.
module conv_line_buf
    import conv_pkg::*;
#(
    parameter int DEPTH  = conv_pkg::IMG_W,
    parameter int DATA_W = conv_pkg::DATA_W,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    // Read returns the value from one row ago; the write replaces it on the same edge.
    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/conv_window_gen.sv
// Raster pixel stream to 3x3 valid-padding windows with position tags.
// Optional build macro CONV_STRIDE2_EN: emit only windows at even row/column origins.
module conv_window_gen
    import conv_pkg::*;
#(
    parameter int IMG_W  = conv_pkg::IMG_W,
    parameter int IMG_H  = conv_pkg::IMG_H,
    parameter int DATA_W = conv_pkg::DATA_W
) (
    input  logic             clk,
    input  logic             rst,
    conv_window_gen_if.slave bus
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
`ifdef CONV_STRIDE2_EN
    localparam int STRIDE = 2;
`else
    localparam int STRIDE = 1;
`endif
    localparam int LAST_R = last_origin(IMG_H, STRIDE) + KERNEL_SIZE - 1;
    localparam int LAST_C = last_origin(IMG_W, STRIDE) + KERNEL_SIZE - 1;

    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic [DATA_W-1:0] win [0:WIN_N-1];
    logic [DATA_W-1:0] lb0_q;
    logic [DATA_W-1:0] lb1_q;
    logic [RW-1:0]     win_row_q;
    logic [CW-1:0]     win_col_q;
    logic              win_valid_q;
    logic              win_last_q;
    logic              accept;
    logic              in_range;
    logic              on_stride;
    logic              emit;
    logic              at_last;

    assign bus.pix_ready = !win_valid_q || bus.win_ready;
    assign accept        = bus.pix_valid && bus.pix_ready;
    assign in_range      = (row >= RW'(KERNEL_SIZE - 1)) && (col >= CW'(KERNEL_SIZE - 1));
`ifdef CONV_STRIDE2_EN
    // (r-2) even <=> r even, likewise for columns.
    assign on_stride     = !row[0] && !col[0];
`else
    assign on_stride     = 1'b1;
`endif
    assign emit          = accept && in_range && on_stride;
    assign at_last       = (row == RW'(LAST_R)) && (col == CW'(LAST_C));

    conv_line_buf #(
        .DEPTH (IMG_W),
        .DATA_W(DATA_W)
    ) u_linebuf0 (
        .clk  (clk),
        .we   (accept),
        .addr (col),
        .wdata(bus.pix_data),
        .rdata(lb0_q)
    );

    conv_line_buf #(
        .DEPTH (IMG_W),
        .DATA_W(DATA_W)
    ) u_linebuf1 (
        .clk  (clk),
        .we   (accept),
        .addr (col),
        .wdata(lb0_q),
        .rdata(lb1_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col == CW'(IMG_W - 1)) begin
                col <= '0;
                row <= (row == RW'(IMG_H - 1)) ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // The shift register doubles as the output window; it only moves on an accepted
    // pixel, and no pixel is accepted while a window is stalled, so the output holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < WIN_N; i++) begin
                win[i] <= '0;
            end
        end else if (accept) begin
            for (int k = 0; k < KERNEL_SIZE; k++) begin
                for (int j = 0; j < KERNEL_SIZE - 1; j++) begin
                    win[k*KERNEL_SIZE + j] <= win[k*KERNEL_SIZE + j + 1];
                end
            end
            win[KERNEL_SIZE - 1]     <= lb1_q;
            win[2*KERNEL_SIZE - 1]   <= lb0_q;
            win[WIN_N - 1]           <= bus.pix_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_valid_q <= 1'b0;
            win_last_q  <= 1'b0;
            win_row_q   <= '0;
            win_col_q   <= '0;
        end else if (emit) begin
            win_valid_q <= 1'b1;
            win_last_q  <= at_last;
            win_row_q   <= row - RW'(KERNEL_SIZE - 1);
            win_col_q   <= col - CW'(KERNEL_SIZE - 1);
        end else if (bus.win_ready) begin
            win_valid_q <= 1'b0;
        end
    end

    for (genvar g = 0; g < WIN_N; g++) begin : g_win_out
        assign bus.win_data[g] = win[g];
    end

    assign bus.win_valid  = win_valid_q;
    assign bus.win_row    = win_row_q;
    assign bus.win_col    = win_col_q;
    assign bus.frame_done = win_valid_q && bus.win_ready && win_last_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// Bench for conv_window_gen: 4x4, 6x6 and 5x5 instances against a frame-level window model.
`timescale 1ns/1ps
module tb_conv_window_gen;
    import conv_pkg::*;

`ifdef CONV_STRIDE2_EN
    localparam int STRIDE = 2;
`else
    localparam int STRIDE = 1;
`endif

    typedef struct packed {
        logic [8:0][31:0] d;
        int               row;
        int               col;
        logic             fd;
    } win_rec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    conv_window_gen_if #(.DATA_W(32), .IMG_W(4), .IMG_H(4)) if4 ();
    conv_window_gen_if #(.DATA_W(32), .IMG_W(6), .IMG_H(6)) if6 ();
    conv_window_gen_if #(.DATA_W(32), .IMG_W(5), .IMG_H(5)) if5 ();

    conv_window_gen #(.IMG_W(4), .IMG_H(4), .DATA_W(32)) dut4 (.clk(clk), .rst(rst), .bus(if4));
    conv_window_gen #(.IMG_W(6), .IMG_H(6), .DATA_W(32)) dut6 (.clk(clk), .rst(rst), .bus(if6));
    conv_window_gen #(.IMG_W(5), .IMG_H(5), .DATA_W(32)) dut5 (.clk(clk), .rst(rst), .bus(if5));

    int          sel;
    logic        pv;
    logic        wr;
    logic [31:0] pd;
    logic        pr;
    logic        wv;
    logic        fd;
    logic [31:0] wd [0:8];
    int          wrow;
    int          wcol;

    assign if4.pix_valid = (sel == 4) && pv;
    assign if6.pix_valid = (sel == 6) && pv;
    assign if5.pix_valid = (sel == 5) && pv;
    assign if4.pix_data  = pd;
    assign if6.pix_data  = pd;
    assign if5.pix_data  = pd;
    assign if4.win_ready = (sel == 4) ? wr : 1'b1;
    assign if6.win_ready = (sel == 6) ? wr : 1'b1;
    assign if5.win_ready = (sel == 5) ? wr : 1'b1;

    always_comb begin
        pr = 1'b0; wv = 1'b0; fd = 1'b0; wrow = 0; wcol = 0;
        for (int i = 0; i < 9; i++) wd[i] = '0;
        case (sel)
            4: begin
                pr = if4.pix_ready; wv = if4.win_valid; fd = if4.frame_done;
                wrow = int'(if4.win_row); wcol = int'(if4.win_col);
                for (int i = 0; i < 9; i++) wd[i] = if4.win_data[i];
            end
            6: begin
                pr = if6.pix_ready; wv = if6.win_valid; fd = if6.frame_done;
                wrow = int'(if6.win_row); wcol = int'(if6.win_col);
                for (int i = 0; i < 9; i++) wd[i] = if6.win_data[i];
            end
            5: begin
                pr = if5.pix_ready; wv = if5.win_valid; fd = if5.frame_done;
                wrow = int'(if5.win_row); wcol = int'(if5.win_col);
                for (int i = 0; i < 9; i++) wd[i] = if5.win_data[i];
            end
            default: ;
        endcase
    end

    int          n_cmp = 0;
    int          n_err = 0;
    int          ready_mode = 0;
    int          fd_cnt = 0;
    logic [31:0] pix_q [$];
    win_rec_t    exp_q [$];
    win_rec_t    obs_q [$];
    int          obs_cyc [$];
    int          acc_cyc [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: enumerate every stride-aligned 3x3 origin of each frame in raster order.
    task automatic build_exp(input int w, input int h);
        int       nf;
        win_rec_t rec;
        nf = pix_q.size() / (w * h);
        for (int f = 0; f < nf; f++) begin
            for (int r0 = 0; r0 <= h - 3; r0 += STRIDE) begin
                for (int c0 = 0; c0 <= w - 3; c0 += STRIDE) begin
                    for (int i = 0; i < 3; i++)
                        for (int j = 0; j < 3; j++)
                            rec.d[i*3 + j] = pix_q[f*w*h + (r0 + i)*w + c0 + j];
                    rec.row = r0;
                    rec.col = c0;
                    rec.fd  = (r0 + STRIDE > h - 3) && (c0 + STRIDE > w - 3);
                    exp_q.push_back(rec);
                end
            end
        end
    endtask

    task automatic clear();
        pix_q.delete(); exp_q.delete(); obs_q.delete(); obs_cyc.delete(); acc_cyc.delete();
        fd_cnt = 0;
    endtask

    task automatic send(input bit gaps);
        int idx = 0;
        int iter = 0;
        bit hs;
        while (idx < pix_q.size()) begin
            if (iter > 5000) begin
                chk("send_timeout", idx, pix_q.size());
                break;
            end
            iter++;
            pv = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            pd = pix_q[idx];
            @(negedge clk);
            hs = pv && pr;
            @(posedge clk); #1;
            if (hs) begin
                acc_cyc.push_back(cyc);
                idx++;
            end
        end
        pv = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (obs_q.size() < exp_q.size() && t < 400) begin
            @(posedge clk); #1;
            t++;
        end
        repeat (4) begin @(posedge clk); #1; end
    endtask

    task automatic compare(input string tag);
        chk({tag, ":nwin"}, obs_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
            for (int i = 0; i < 9; i++)
                chk($sformatf("%s:w%0d.d%0d", tag, k, i), obs_q[k].d[i], exp_q[k].d[i]);
            chk($sformatf("%s:w%0d.row", tag, k), obs_q[k].row, exp_q[k].row);
            chk($sformatf("%s:w%0d.col", tag, k), obs_q[k].col, exp_q[k].col);
            chk($sformatf("%s:w%0d.fd", tag, k), obs_q[k].fd, exp_q[k].fd);
        end
    endtask

    task automatic hold_check();
        int          t = 0;
        logic [31:0] snap [0:8];
        int          srow;
        int          scol;
        while (!wv && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("s2:held_valid", wv, 1);
        for (int i = 0; i < 9; i++) begin
            snap[i] = wd[i];
            chk($sformatf("s2:first.d%0d", i), wd[i], exp_q.size() > 0 ? exp_q[0].d[i] : 32'hdead);
        end
        srow = wrow;
        scol = wcol;
        repeat (5) begin
            @(negedge clk);
            chk("s2:pix_ready_low", pr, 0);
            chk("s2:valid_kept", wv, 1);
            chk("s2:row_stable", wrow, srow);
            chk("s2:col_stable", wcol, scol);
            for (int i = 0; i < 9; i++) chk($sformatf("s2:d%0d_stable", i), wd[i], snap[i]);
        end
        ready_mode = 0;
    endtask

    initial begin
        wr = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       wr = 1'b1;
                1:       wr = ($urandom_range(0, 2) != 0);
                default: wr = 1'b0;
            endcase
        end
    end

    initial begin
        win_rec_t rec;
        forever begin
            @(negedge clk);
            if (wv && wr) begin
                for (int i = 0; i < 9; i++) rec.d[i] = wd[i];
                rec.row = wrow;
                rec.col = wcol;
                rec.fd  = fd;
                obs_q.push_back(rec);
                obs_cyc.push_back(cyc);
            end
            if (fd) fd_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        pv = 1'b0; pd = '0; sel = 4;
        #2 rst = 1'b1;
        #6;
        chk("rst:win_valid", wv, 0);
        chk("rst:win_row", wrow, 0);
        chk("rst:win_col", wcol, 0);
        chk("rst:frame_done", fd, 0);
        chk("rst:win_data0", wd[0], 0);
        chk("rst:win_data8", wd[8], 0);
        chk("rst:pix_ready", pr, 1);
        @(posedge clk); #1;
        rst = 1'b0;

        // Scenario 1: single 4x4 frame, consumer always ready.
        clear();
        for (int i = 0; i < 16; i++) pix_q.push_back(i);
        build_exp(4, 4);
        send(1'b0);
        drain();
        compare("s1");
        chk("s1:latency", obs_cyc.size() > 0 ? obs_cyc[0] : -1,
            acc_cyc.size() > 10 ? acc_cyc[10] : -2);
        chk("s1:fd_cnt", fd_cnt, 1);

        // Scenario 2: stall the first window for five cycles.
        clear();
        for (int i = 0; i < 16; i++) pix_q.push_back(i);
        build_exp(4, 4);
        ready_mode = 2;
        fork
            send(1'b0);
            hold_check();
        join
        drain();
        compare("s2");
        chk("s2:fd_cnt", fd_cnt, 1);

        // Scenario 3: two frames back to back.
        clear();
        for (int i = 0; i < 16; i++) pix_q.push_back(i);
        for (int i = 0; i < 16; i++) pix_q.push_back(100 + i);
        build_exp(4, 4);
        send(1'b0);
        drain();
        compare("s3");
        chk("s3:fd_cnt", fd_cnt, 2);

        // Scenario 4: reset with a window pending, then a fresh frame.
        clear();
        for (int i = 0; i < 11; i++) pix_q.push_back(i);
        ready_mode = 2;
        send(1'b0);
        @(negedge clk);
        chk("s4:pending_before_rst", wv, 1);
        rst = 1'b1;
        #1;
        chk("s4:rst_valid", wv, 0);
        chk("s4:rst_pix_ready", pr, 1);
        chk("s4:rst_data8", wd[8], 0);
        chk("s4:rst_row", wrow, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        ready_mode = 0;
        chk("s4:dropped", obs_q.size(), 0);
        clear();
        for (int i = 0; i < 16; i++) pix_q.push_back(i);
        build_exp(4, 4);
        send(1'b0);
        drain();
        compare("s4");
        chk("s4:fd_cnt", fd_cnt, 1);

        // Scenario 5: 6x6, random data with random gaps on both sides, two frames.
        sel = 6;
        @(posedge clk); #1;
        clear();
        for (int i = 0; i < 72; i++) pix_q.push_back($urandom);
        build_exp(6, 6);
        ready_mode = 1;
        send(1'b1);
        drain();
        ready_mode = 0;
        drain();
        compare("s5");
        chk("s5:fd_cnt", fd_cnt, 2);

        // Scenario 6: 5x5 frame; window set follows the build's stride.
        sel = 5;
        @(posedge clk); #1;
        clear();
        for (int i = 0; i < 25; i++) pix_q.push_back(i);
        build_exp(5, 5);
        send(1'b0);
        drain();
        compare("s6");
        chk("s6:fd_cnt", fd_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
